// File: rtl/ifft_out_serializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ifft_out_serializer_pkg
//  Description : Shared constants, read-phase type and the saturating
//                convergent-rounding helper for the IFFT output serializer.
//  Revision    : 1.0  initial release
// ============================================================================
package ifft_out_serializer_pkg;

  localparam int IWIDTH  = 21;
  localparam int OWIDTH  = 16;
  localparam int SHIFT   = 2;
  localparam int LGWIDTH = 11;
  localparam int LGFIFO  = 4;

  // One FIFO entry: {sync, L.re, L.im, R.re, R.im}
  localparam int ENTRY_W = 1 + 4 * OWIDTH;
  localparam int DEPTH   = 2 ** LGFIFO;
  localparam int FRAME   = 2 ** LGWIDTH;

  typedef enum logic {
    PH_LEFT  = 1'b0,
    PH_RIGHT = 1'b1
  } phase_e;

  // Saturate an iw-bit signed value to iw-sh bits, then convergently round
  // away the remaining iw-sh-ow LSBs. A rounding carry that would overflow
  // clamps to the largest positive ow-bit value. Result in the low ow bits.
  function automatic logic [31:0] conv_round(input logic [63:0] x,
                                             input int iw,
                                             input int ow,
                                             input int sh);
    logic signed [63:0] xs;
    logic signed [63:0] smax;
    logic signed [63:0] smin;
    logic signed [63:0] sat;
    logic signed [63:0] sum;
    logic signed [63:0] res;
    int                 mw;
    int                 d;
    mw   = iw - sh;
    d    = mw - ow;
    xs   = $signed(x << (64 - iw)) >>> (64 - iw);
    smax = (64'sd1 <<< (mw - 1)) - 64'sd1;
    smin = -(64'sd1 <<< (mw - 1));
    if (xs > smax)      sat = smax;
    else if (xs < smin) sat = smin;
    else                sat = xs;
    sum = sat + ((64'sd1 <<< (d - 1)) - 64'sd1) + ((sat >>> d) & 64'sd1);
    if (sum > smax) res = (64'sd1 <<< (ow - 1)) - 64'sd1;
    else            res = sum >>> d;
    return res[31:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/ifft_out_serializer_convround.sv
`default_nettype none
// ============================================================================
//  Module      : convround
//  Description : One component of the output path: saturate, convergently
//                round and register on the capture enable.
//  Revision    : 1.0  initial release
// ============================================================================
module convround
  import ifft_out_serializer_pkg::*;
#(
  parameter int IN_W     = 21,
  parameter int OUT_W    = 16,
  parameter int DROP_MSB = 2
) (
  input  logic             clk_i,
  input  logic             ce_i,
  input  logic [IN_W-1:0]  x_i,
  output logic [OUT_W-1:0] y_o
);

  logic [OUT_W-1:0] y_q;

  // Capture the rounded component only for pairs that enter the FIFO
  always_ff @(posedge clk_i) begin
    if (ce_i) begin
      y_q <= OUT_W'(conv_round({{(64-IN_W){1'b0}}, x_i}, IN_W, OUT_W, DROP_MSB));
    end
  end

  assign y_o = y_q;

endmodule
`default_nettype wire

// File: rtl/ifft_out_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : ifft_out_serializer
//  Description : Captures two-sample-per-clock IFFT output pairs, rounds them,
//                buffers them and replays one sample per clock on a
//                valid/ready stream with frame first/last markers.
//  Revision    : 1.0  initial release
// ============================================================================
module ifft_out_serializer
  import ifft_out_serializer_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_ce,
  input  logic [2*IWIDTH-1:0]   i_left,
  input  logic [2*IWIDTH-1:0]   i_right,
  input  logic                  i_sync,
  output logic                  o_room,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [2*OWIDTH-1:0]   o_data,
  output logic                  o_first,
  output logic                  o_last,
  output logic                  o_overflow,
  output logic                  o_sync_err
);

  localparam logic [LGFIFO:0]    CNT_ONE  = {{LGFIFO{1'b0}}, 1'b1};
  localparam logic [LGFIFO-1:0]  PTR_ONE  = {{(LGFIFO-1){1'b0}}, 1'b1};
  localparam logic [LGWIDTH-1:0] IDX_ONE  = {{(LGWIDTH-1){1'b0}}, 1'b1};
  localparam logic [LGWIDTH-1:0] IDX_LAST = LGWIDTH'(FRAME - 1);

  // ---------------------------------------------------------------- state
  // count_q counts reserved slots: it rises when a pair is accepted, one
  // cycle before the rounded data lands in memory (pend_q marks that slot).
  logic                  started_q, started_d;
  logic                  pend_q,    pend_d;
  logic                  sync_q,    sync_d;
  logic [LGFIFO:0]       count_q,   count_d;
  logic [LGFIFO-1:0]     wr_ptr_q,  wr_ptr_d;
  logic [LGFIFO-1:0]     rd_ptr_q,  rd_ptr_d;
  phase_e                phase_q,   phase_d;
  logic [LGWIDTH-1:0]    frame_q,   frame_d;
  logic                  ovf_q,     ovf_d;
  logic                  serr_q,    serr_d;
  logic [ENTRY_W-1:0]    mem_q [DEPTH];

  logic                  w_take;
  logic                  w_accept;
  logic                  w_valid;
  logic                  w_hs;
  logic                  w_pop;
  logic                  w_force;
  logic [LGWIDTH-1:0]    w_idx;
  logic [ENTRY_W-1:0]    w_head;
  logic [4*IWIDTH-1:0]   w_in;
  logic [4*OWIDTH-1:0]   w_rnd;

  // ------------------------------------------------------------ write side
  assign w_take   = i_ce & (started_q | i_sync);
  assign w_accept = w_take & ~count_q[LGFIFO];
  assign w_in     = {i_left, i_right};

  for (genvar k = 0; k < 4; k++) begin : g_round
    convround #(
      .IN_W     (IWIDTH),
      .OUT_W    (OWIDTH),
      .DROP_MSB (SHIFT)
    ) u_round (
      .clk_i (i_clk),
      .ce_i  (w_accept),
      .x_i   (w_in[(4-k)*IWIDTH-1 -: IWIDTH]),
      .y_o   (w_rnd[(4-k)*OWIDTH-1 -: OWIDTH])
    );
  end

  // ------------------------------------------------------------- read side
  assign w_head  = mem_q[rd_ptr_q];
  assign w_valid = (count_q > {{LGFIFO{1'b0}}, pend_q});
  assign w_hs    = w_valid & i_ready;
  assign w_pop   = w_hs & (phase_q == PH_RIGHT);
  assign w_force = w_valid & w_head[ENTRY_W-1] & (phase_q == PH_LEFT);
  assign w_idx   = w_force ? '0 : frame_q;

  // State register with synchronous active-low reset (also flushes the FIFO)
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      started_q <= 1'b0;
      pend_q    <= 1'b0;
      sync_q    <= 1'b0;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      phase_q   <= PH_LEFT;
      frame_q   <= '0;
      ovf_q     <= 1'b0;
      serr_q    <= 1'b0;
    end else begin
      started_q <= started_d;
      pend_q    <= pend_d;
      sync_q    <= sync_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      phase_q   <= phase_d;
      frame_q   <= frame_d;
      ovf_q     <= ovf_d;
      serr_q    <= serr_d;
    end
  end

  // Land the rounded pair one cycle after acceptance
  always_ff @(posedge i_clk) begin
    if (pend_q) begin
      mem_q[wr_ptr_q] <= {sync_q, w_rnd};
    end
  end

  // Next-state logic: start gating, occupancy, pointers, phase and index
  always_comb begin
    started_d = started_q | (i_ce & i_sync);
    pend_d    = w_accept;
    sync_d    = w_accept & i_sync;
    count_d   = count_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    phase_d   = phase_q;
    frame_d   = frame_q;
    ovf_d     = ovf_q | (w_take & count_q[LGFIFO]);
    serr_d    = serr_q | (w_force & (frame_q != '0));

    unique case ({w_accept, w_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    if (pend_q) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (w_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;

    if (w_hs) begin
      phase_d = (phase_q == PH_LEFT) ? PH_RIGHT : PH_LEFT;
      frame_d = w_idx + IDX_ONE;
    end
  end

  // Output decode from the FIFO head and registered state
  always_comb begin
    o_room     = ~count_q[LGFIFO];
    o_valid    = w_valid;
    o_data     = (phase_q == PH_LEFT) ? w_head[4*OWIDTH-1 -: 2*OWIDTH]
                                      : w_head[2*OWIDTH-1:0];
    o_first    = w_valid & (w_idx == '0);
    o_last     = w_valid & (w_idx == IDX_LAST);
    o_overflow = ovf_q;
    o_sync_err = serr_q;
  end

endmodule
`default_nettype wire
